// File: rtl/palette_ram_pkg.sv
// palette_ram_pkg: shared sizes, FSM encoding and delay helper for the
// palette block.
//   PAL_ENTRIES / PAL_IDX_W : palette depth and index width
//   COLOR_W                 : colour byte width {B[1:0],G[2:0],R[2:0]}
//   CNT_W                   : width of the write-delay counter
package palette_ram_pkg;

   localparam int PAL_ENTRIES = 16;
   localparam int PAL_IDX_W   = 4;
   localparam int COLOR_W     = 8;
   localparam int CNT_W       = 4;

   typedef enum logic {
      PAL_IDLE = 1'b0,
      PAL_PEND = 1'b1
   } pal_state_e;

   // A delay of 0 would never commit, so it behaves as 1; the counter
   // cannot hold more than 15.
   function automatic logic [CNT_W-1:0] eff_delay(input int d);
      if (d < 1)
         return CNT_W'(1);
      else if (d > 15)
         return CNT_W'(15);
      else
         return d[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/palette_ram_if.sv
// palette_ram_if: CPU write strobe and video read path of the palette.
//   coloridx   : palette read address from video (border or pixel index)
//   border_idx : border colour index register
//   pal_wr     : CPU palette write strobe (level)
//   pal_data   : colour byte, valid while pal_wr is high
//   realcolor  : registered palette entry for coloridx
//   pal_busy   : a write is pending
// master = CPU decoder / video side, slave = palette.
interface palette_ram_if;
   import palette_ram_pkg::*;

   logic [PAL_IDX_W-1:0] coloridx;
   logic [PAL_IDX_W-1:0] border_idx;
   logic                 pal_wr;
   logic [COLOR_W-1:0]   pal_data;
   logic [COLOR_W-1:0]   realcolor;
   logic                 pal_busy;

   modport master (
      output coloridx, border_idx, pal_wr, pal_data,
      input  realcolor, pal_busy
   );

   modport slave (
      input  coloridx, border_idx, pal_wr, pal_data,
      output realcolor, pal_busy
   );

endinterface

// File: rtl/palette_ram_regfile.sv
// palette_regfile: 16 x 8 palette storage.
//   clk, reset : clock, synchronous active-high clear of every entry
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : registered read port (1 cycle latency)
// A write to the entry being read shows up on rdata in the same cycle
// as the write, because the read is taken from the post-write array.
module palette_regfile
   import palette_ram_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [PAL_IDX_W-1:0] waddr,
   input  logic [COLOR_W-1:0]   wdata,
   input  logic [PAL_IDX_W-1:0] raddr,
   output logic [COLOR_W-1:0]   rdata
);

   logic [PAL_ENTRIES-1:0][COLOR_W-1:0] mem_q, mem_d;
   logic [COLOR_W-1:0]                  rdata_q, rdata_d;

   always_comb begin
      mem_d = mem_q;
      if (we)
         mem_d[waddr] = wdata;
      rdata_d = mem_d[raddr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '0;
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/palette_ram.sv
// palette_ram: colour palette with delayed CPU writes.
//   clk24 : 24 MHz system clock
//   reset : synchronous, active-high; drops any pending write, clears palette
//   ce6   : 6 MHz pixel enable, one clk24 pulse in four
//   bus   : palette_ram_if slave (strobe/data in, realcolor/pal_busy out)
// A rising edge on pal_wr captures the data; the write lands on the
// WR_DELAY-th ce6 after the edge. With ADDR_BORDER=0 the target entry is
// whatever coloridx is on screen in that commit cycle, otherwise the
// border index captured with the strobe.
module palette_ram
   import palette_ram_pkg::*;
#(
   parameter int WR_DELAY    = 4,
   parameter int ADDR_BORDER = 0
) (
   input  logic          clk24,
   input  logic          reset,
   input  logic          ce6,
   palette_ram_if.slave  bus
);

   localparam logic [CNT_W-1:0] DLY = eff_delay(WR_DELAY);

   pal_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pal_wr_q;
   logic [COLOR_W-1:0]   wdata_q, wdata_d;
   logic [PAL_IDX_W-1:0] waddr_q, waddr_d;
   logic                 wr_edge, commit;
   logic [PAL_IDX_W-1:0] wr_addr;

   always_ff @(posedge clk24) begin
      if (reset) begin
         state_q  <= PAL_IDLE;
         cnt_q    <= '0;
         pal_wr_q <= 1'b0;
         wdata_q  <= '0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pal_wr_q <= bus.pal_wr;
         wdata_q  <= wdata_d;
         waddr_q  <= waddr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      wr_edge = bus.pal_wr & ~pal_wr_q;
      commit  = (state_q == PAL_PEND) && ce6 && (cnt_q == CNT_W'(1));

      if (state_q == PAL_PEND && ce6 && cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
      if (commit)
         state_d = PAL_IDLE;

      // The edge overrides the decrement (a ce6 on the edge cycle does not
      // count) and, in a commit cycle, re-arms after the old data lands.
      if (wr_edge) begin
         state_d = PAL_PEND;
         cnt_d   = DLY;
         wdata_d = bus.pal_data;
         if (ADDR_BORDER != 0)
            waddr_d = bus.border_idx;
      end

      wr_addr = (ADDR_BORDER != 0) ? waddr_q : bus.coloridx;
   end

   palette_regfile u_regfile (
      .clk   (clk24),
      .reset (reset),
      .we    (commit),
      .waddr (wr_addr),
      .wdata (wdata_q),
      .raddr (bus.coloridx),
      .rdata (bus.realcolor)
   );

   assign bus.pal_busy = (state_q == PAL_PEND);

endmodule

// File: tb/tb_palette_ram.sv
module tb_palette_ram;
   import palette_ram_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic ce6;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #10 clk = ~clk;

   palette_ram_if ifa ();
   palette_ram_if ifb ();

   palette_ram #(.WR_DELAY(4), .ADDR_BORDER(0)) dut (
      .clk24 (clk),
      .reset (reset),
      .ce6   (ce6),
      .bus   (ifa)
   );

   palette_ram #(.WR_DELAY(4), .ADDR_BORDER(1)) dut_b (
      .clk24 (clk),
      .reset (reset),
      .ce6   (ce6),
      .bus   (ifb)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cyc(input logic ce);
      ce6 = ce;
      @(posedge clk);
      #1;
      ce6 = 1'b0;
   endtask

   task automatic ce_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
      end
   endtask

   initial begin
      reset = 1'b1;
      ce6   = 1'b0;
      ifa.coloridx = 4'd0; ifa.border_idx = 4'd0; ifa.pal_wr = 1'b0; ifa.pal_data = 8'h00;
      ifb.coloridx = 4'd0; ifb.border_idx = 4'd0; ifb.pal_wr = 1'b0; ifb.pal_data = 8'h00;
      cyc(1'b0); cyc(1'b0);
      chk("rst_realcolor", ifa.realcolor, 8'h00);
      chk("rst_busy", {7'd0, ifa.pal_busy}, 8'h00);
      reset = 1'b0;

      // 1: cleared palette sweep
      for (int i = 0; i < 16; i++) begin
         ifa.coloridx = 4'(i);
         cyc(1'b0);
         chk($sformatf("t1_idx%0d", i), ifa.realcolor, 8'h00);
      end

      // 2: long strobe, one write after 4 ce6, bypass on commit
      ifa.coloridx = 4'd5; ifa.pal_data = 8'hA7; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      chk("t2_busy_edge", {7'd0, ifa.pal_busy}, 8'h01);
      ce_ticks(3);
      chk("t2_busy_3ce", {7'd0, ifa.pal_busy}, 8'h01);
      chk("t2_pre_commit", ifa.realcolor, 8'h00);
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
      chk("t2_bypass", ifa.realcolor, 8'hA7);
      chk("t2_busy_done", {7'd0, ifa.pal_busy}, 8'h00);
      ce_ticks(9);
      chk("t2_held_no_rewrite", {7'd0, ifa.pal_busy}, 8'h00);
      ifa.pal_wr = 1'b0;
      cyc(1'b0);
      chk("t2_entry5", ifa.realcolor, 8'hA7);

      // 3: address follows coloridx at commit time
      ifa.coloridx = 4'd2; ifa.pal_data = 8'h3C; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      ifa.pal_wr = 1'b0;
      ce_ticks(2);
      ifa.coloridx = 4'd9;
      ce_ticks(2);
      chk("t3_bypass9", ifa.realcolor, 8'h3C);
      ifa.coloridx = 4'd2; cyc(1'b0);
      chk("t3_entry2", ifa.realcolor, 8'h00);
      ifa.coloridx = 4'd9; cyc(1'b0);
      chk("t3_entry9", ifa.realcolor, 8'h3C);

      // 4: second strobe restarts the delay, last write wins
      ifa.coloridx = 4'd0; ifa.pal_data = 8'h11; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      ifa.pal_wr = 1'b0;
      ce_ticks(2);
      ifa.pal_data = 8'h22; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      ifa.pal_wr = 1'b0;
      ce_ticks(3);
      chk("t4_busy_3ce", {7'd0, ifa.pal_busy}, 8'h01);
      chk("t4_no_early", ifa.realcolor, 8'h00);
      ce_ticks(1);
      chk("t4_entry0", ifa.realcolor, 8'h22);
      chk("t4_busy_done", {7'd0, ifa.pal_busy}, 8'h00);

      // 5: edge in the commit cycle, both writes land
      ifa.coloridx = 4'd1; ifa.pal_data = 8'h55; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      ifa.pal_wr = 1'b0;
      ce_ticks(3);
      cyc(1'b0); cyc(1'b0); cyc(1'b0);
      ifa.pal_data = 8'hAA; ifa.pal_wr = 1'b1;
      cyc(1'b1);
      chk("t5_first", ifa.realcolor, 8'h55);
      chk("t5_busy_rearm", {7'd0, ifa.pal_busy}, 8'h01);
      ifa.pal_wr = 1'b0; ifa.coloridx = 4'd3;
      ce_ticks(3);
      chk("t5_entry3_pre", ifa.realcolor, 8'h00);
      ce_ticks(1);
      chk("t5_second", ifa.realcolor, 8'hAA);
      chk("t5_busy_done", {7'd0, ifa.pal_busy}, 8'h00);
      ifa.coloridx = 4'd1; cyc(1'b0);
      chk("t5_entry1", ifa.realcolor, 8'h55);

      // 6: reset while pending
      ifa.coloridx = 4'd6; ifa.pal_data = 8'hF0; ifa.pal_wr = 1'b1;
      cyc(1'b0);
      ifa.pal_wr = 1'b0;
      ce_ticks(2);
      reset = 1'b1;
      cyc(1'b0);
      chk("t6_busy_rst", {7'd0, ifa.pal_busy}, 8'h00);
      chk("t6_realcolor_rst", ifa.realcolor, 8'h00);
      reset = 1'b0;
      ce_ticks(4);
      chk("t6_no_commit", ifa.realcolor, 8'h00);
      chk("t6_busy_idle", {7'd0, ifa.pal_busy}, 8'h00);
      ifa.coloridx = 4'd1; cyc(1'b0);
      chk("t6_entry1_clr", ifa.realcolor, 8'h00);
      ifa.coloridx = 4'd5; cyc(1'b0);
      chk("t6_entry5_clr", ifa.realcolor, 8'h00);

      // 7: border-addressed instance uses the index latched at the strobe
      ifb.border_idx = 4'd7; ifb.coloridx = 4'd12; ifb.pal_data = 8'h9E; ifb.pal_wr = 1'b1;
      cyc(1'b0);
      ifb.pal_wr = 1'b0; ifb.border_idx = 4'd3;
      ce_ticks(4);
      chk("t7_busy_done", {7'd0, ifb.pal_busy}, 8'h00);
      chk("t7_entry12", ifb.realcolor, 8'h00);
      ifb.coloridx = 4'd7; cyc(1'b0);
      chk("t7_entry7", ifb.realcolor, 8'h9E);
      ifb.coloridx = 4'd3; cyc(1'b0);
      chk("t7_entry3", ifb.realcolor, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
